rram_adc_accumulator: RTL and testbench

- Downstream consumer of the RRAM core's ADC outputs during bit-serial MAC operation.
- Each accepted beat is one input bit-slice: NUM_ADCS column conversions ADCout[i].
- Per-column shift-add accumulation over INPUT_BITS slices, LSB slice first.
- Completed column sums are drained one column per beat over a valid/ready stream toward the digital back end.

---
 rtl/rram_adc_accumulator.sv | 145 ++++++++++++++
 tb/tb_rram_adc_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_adc_accumulator.sv
// rram_adc_accumulator
//
// Bit-serial MAC back end for the RRAM core. Each accepted input beat is one
// bit-slice of the input vector, carrying one ADC code per column. Slices
// arrive LSB first, and each code is weighted by 2^slice before it is added
// to that column's running sum. After INPUT_BITS slices, the column sums are
// streamed out one column per beat over a valid/ready interface. The sums are
// then cleared and the block returns to accepting slices.
//
// Ports
//   CLK        in   single clock
//   RESET_N    in   asynchronous active-low reset
//   IN_VALID   in   slice valid from the core
//   IN_READY   out  slice can be accepted (ACCUM only)
//   ADCout     in   NUM_ADCS x ADC_W column codes, sampled on accept
//   RES_VALID  out  result beat valid (DRAIN only)
//   RES_READY  in   downstream accepts the result beat
//   RES_DATA   out  accumulated sum of column RES_COL
//   RES_COL    out  column index of the current beat
//   RES_LAST   out  high on the beat for the last column
//   BUSY       out  a frame is partially accumulated or being drained
//
// state | meaning
// ------+---------------------------------------------------------------
// ACCUM | accepting slices; shift-add into every column in parallel
// DRAIN | presenting acc[col] one column per handshake; no slice accept

module rram_adc_accumulator #(
    parameter int NUM_ADCS   = 32,
    parameter int ADC_W      = 4,
    parameter int INPUT_BITS = 8,
    localparam int ACC_W     = ADC_W + INPUT_BITS,
    localparam int COL_W     = $clog2(NUM_ADCS)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [ADC_W-1:0] ADCout [NUM_ADCS],
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [ACC_W-1:0] RES_DATA,
    output logic [COL_W-1:0] RES_COL,
    output logic             RES_LAST,
    output logic             BUSY
);

    // Slice counter must hold 0..INPUT_BITS-1; keep it at least one bit wide
    // so INPUT_BITS=1 still elaborates.
    localparam int SC_W = (INPUT_BITS > 1) ? $clog2(INPUT_BITS) : 1;
    localparam logic [SC_W-1:0]  LAST_SLICE = SC_W'(INPUT_BITS - 1);
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(NUM_ADCS - 1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  slice_q, slice_d;
    logic [COL_W-1:0] col_q,   col_d;
    logic [ACC_W-1:0] acc_q [NUM_ADCS];
    logic [ACC_W-1:0] acc_d [NUM_ADCS];

    logic in_ready;
    logic res_valid;

    always_comb begin
        state_d   = state_q;
        slice_d   = slice_q;
        col_d     = col_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        res_valid = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (IN_VALID) begin
                    // Zero-extend before shifting: the widest term is
                    // (2^ADC_W-1) << (INPUT_BITS-1), and the full sum still
                    // fits in ACC_W, so no bits are ever dropped.
                    for (int i = 0; i < NUM_ADCS; i++) begin
                        acc_d[i] = acc_q[i] + (ACC_W'(ADCout[i]) << slice_q);
                    end
                    if (slice_q == LAST_SLICE) begin
                        slice_d = '0;
                        col_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        slice_d = slice_q + SC_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                res_valid = 1'b1;
                if (RES_READY) begin
                    if (col_q == LAST_COL) begin
                        for (int i = 0; i < NUM_ADCS; i++) begin
                            acc_d[i] = '0;
                        end
                        col_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_ACCUM;
            slice_q <= '0;
            col_q   <= '0;
            for (int i = 0; i < NUM_ADCS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
            col_q   <= col_d;
            for (int i = 0; i < NUM_ADCS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Result beat is a register-fed mux; col_q only moves on a handshake, so
    // the beat stays stable under backpressure. Outside DRAIN, force zero so
    // partial sums never leak onto the result bus.
    assign IN_READY  = in_ready;
    assign RES_VALID = res_valid;
    assign RES_DATA  = (state_q == ST_DRAIN) ? acc_q[col_q] : '0;
    assign RES_COL   = (state_q == ST_DRAIN) ? col_q : '0;
    assign RES_LAST  = (state_q == ST_DRAIN) && (col_q == LAST_COL);
    assign BUSY      = (state_q == ST_DRAIN) || (slice_q != '0);

endmodule

// File: tb/tb_rram_adc_accumulator.sv
module tb_rram_adc_accumulator;

    localparam int N    = 32;
    localparam int AW   = 4;
    localparam int IB   = 8;
    localparam int ACCW = AW + IB;

    logic            CLK;
    logic            RESET_N;
    logic            in_valid;
    logic            IN_READY;
    logic [AW-1:0]   adc [N];
    logic            RES_VALID;
    logic            res_ready;
    logic [ACCW-1:0] RES_DATA;
    logic [4:0]      RES_COL;
    logic            RES_LAST;
    logic            BUSY;

    rram_adc_accumulator #(.NUM_ADCS(N), .ADC_W(AW), .INPUT_BITS(IB)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IN_VALID(in_valid), .IN_READY(IN_READY), .ADCout(adc),
        .RES_VALID(RES_VALID), .RES_READY(res_ready),
        .RES_DATA(RES_DATA), .RES_COL(RES_COL), .RES_LAST(RES_LAST),
        .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endfunction

    // Behavioural model: a frame is a list of IB weighted slices; the result
    // of column i is sum over slices s of code[s][i] * 2^s. Drain emits the
    // columns in order, one per accepted beat.
    int m_acc [N];
    int m_slices;
    bit m_drain;
    int m_col;

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            foreach (m_acc[i]) m_acc[i] = 0;
            m_slices = 0;
            m_drain  = 0;
            m_col    = 0;
        end else if (!m_drain) begin
            if (in_valid) begin
                foreach (m_acc[i]) m_acc[i] += int'(adc[i]) * (2 ** m_slices);
                m_slices++;
                if (m_slices == IB) begin
                    m_slices = 0;
                    m_drain  = 1;
                    m_col    = 0;
                end
            end
        end else if (res_ready) begin
            m_col++;
            if (m_col == N) begin
                m_drain = 0;
                m_col   = 0;
                foreach (m_acc[i]) m_acc[i] = 0;
            end
        end
    end

    // Beat capture and stall bookkeeping at the active edge.
    int got [N];
    int beats;
    int last_cnt;
    int last_col;
    bit stall_seen;
    int stall_data;
    int stall_col;

    always @(posedge CLK) begin
        if (!RESET_N) begin
            stall_seen = 0;
        end else begin
            if (RES_VALID && res_ready) begin
                got[RES_COL] = int'(RES_DATA);
                beats++;
                if (RES_LAST) begin
                    last_cnt++;
                    last_col = int'(RES_COL);
                end
            end
            stall_seen = RES_VALID && !res_ready;
            stall_data = int'(RES_DATA);
            stall_col  = int'(RES_COL);
        end
    end

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    always @(posedge CLK) begin
        #1;
        chk("in_ready",  IN_READY,  !m_drain);
        chk("res_valid", RES_VALID, m_drain);
        chk("busy",      BUSY,      (m_slices != 0) || m_drain);
        if (m_drain) begin
            chk("res_data", RES_DATA, m_acc[m_col]);
            chk("res_col",  RES_COL,  m_col);
            chk("res_last", RES_LAST, m_col == N - 1);
        end
        if (stall_seen && RESET_N) begin
            chk("stall_data", RES_DATA, stall_data);
            chk("stall_col",  RES_COL,  stall_col);
        end
    end

    task automatic clear_capture();
        foreach (got[i]) got[i] = -1;
        beats    = 0;
        last_cnt = 0;
        last_col = -1;
    endtask

    // mode 0: every code = k in every slice
    // mode 1: slice 0 code = i%16, slices 1..6 zero, slice 7 code = 15
    task automatic set_slice(input int mode, input int k, input int s);
        foreach (adc[i]) begin
            if (mode == 0)      adc[i] = AW'(k);
            else if (s == 0)    adc[i] = AW'(i % 16);
            else if (s == IB-1) adc[i] = 4'd15;
            else                adc[i] = 4'd0;
        end
    endtask

    task automatic send_slices(input int mode, input int k, input int count, input bit hold);
        for (int s = 0; s < count; s++) begin
            bit ok;
            @(negedge CLK);
            set_slice(mode, k, s);
            in_valid = 1'b1;
            ok = 0;
            for (int n = 0; n < 200 && !ok; n++) begin
                @(posedge CLK);
                if (IN_READY) ok = 1;
            end
            if (!ok) chk("accept_timeout", 0, 1);
        end
        @(negedge CLK);
        if (hold) foreach (adc[i]) adc[i] = 4'd0;
        else in_valid = 1'b0;
    endtask

    // ready_mode 0: always ready, 1: toggle 1/0, 2: random
    task automatic drain(input int ready_mode);
        for (int n = 0; n < 400 && beats < N; n++) begin
            if (ready_mode == 0)      res_ready = 1'b1;
            else if (ready_mode == 1) res_ready = (n % 2 == 0);
            else                      res_ready = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
        res_ready = 1'b0;
        chk("drain_beats", beats, N);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge CLK);
        RESET_N = 1'b0;
        repeat (cycles) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N   = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        foreach (adc[i]) adc[i] = '0;
        clear_capture();
        #100;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #2;
        chk("rst_in_ready",  IN_READY,  1);
        chk("rst_res_valid", RES_VALID, 0);
        chk("rst_busy",      BUSY,      0);
        chk("rst_res_data",  RES_DATA,  0);

        // All ones: every column sums to 255.
        clear_capture();
        send_slices(0, 1, IB, 0);
        drain(0);
        foreach (got[i]) chk("ones_val", got[i], 255);
        chk("ones_last_cnt", last_cnt, 1);
        chk("ones_last_col", last_col, 31);
        @(posedge CLK); #2;
        chk("ones_ready_after", IN_READY, 1);

        // Slice weighting: LSB slice i%16, MSB slice 15.
        clear_capture();
        send_slices(1, 0, IB, 0);
        drain(0);
        chk("wt_col5",  got[5],  1925);
        chk("wt_col0",  got[0],  1920);
        chk("wt_col20", got[20], 1924);
        chk("wt_col31", got[31], 1935);

        // Max codes: 15 * 255 = 3825 without wrap.
        clear_capture();
        send_slices(0, 15, IB, 0);
        drain(2);
        chk("max_col0",  got[0],  3825);
        chk("max_col31", got[31], 3825);

        // Backpressure with IN_VALID held through the drain.
        clear_capture();
        send_slices(0, 2, IB, 1);
        drain(1);
        chk("bp_col7", got[7], 510);
        @(negedge CLK);
        in_valid = 1'b0;

        // Reset mid-frame discards partial sums.
        send_slices(0, 15, 3, 0);
        do_reset(2);
        clear_capture();
        send_slices(0, 1, IB, 0);
        drain(0);
        foreach (got[i]) chk("rst_mid_val", got[i], 255);

        // Random traffic, including a reset in the middle.
        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            in_valid  = ($urandom_range(0, 3) != 0);
            res_ready = ($urandom_range(0, 2) != 0);
            foreach (adc[i]) adc[i] = AW'($urandom_range(0, 15));
            if (c == 2000) begin
                RESET_N = 1'b0;
                @(negedge CLK);
                RESET_N = 1'b1;
            end
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
